// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction memory request/response plus the
// fetch-to-decode handoff. The master side is driven by fetch_ctrl.
interface fetch_ctrl_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        ds_allowin;

    modport master (
        output inst_req, inst_addr, fs_valid, fs_pc, fs_inst,
        input  inst_addr_ok, inst_data_ok, inst_rdata, ds_allowin
    );

    modport slave (
        input  inst_req, inst_addr, fs_valid, fs_pc, fs_inst,
        output inst_addr_ok, inst_data_ok, inst_rdata, ds_allowin
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding fetch, holds the returned word
// until decode takes it, applies exception/eret flushes and delayed branches.
module fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'hbfc00000,
    parameter logic [31:0] EXC_ADDR   = 32'hbfc00380
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         exc,
    input  logic         eret,
    input  logic [31:0]  epc,
    input  logic         br_valid,
    input  logic [31:0]  br_target,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      r_state;
    logic [31:0] r_req_pc;
    logic        r_cancel;
    logic        r_br_pend;
    logic [31:0] r_br_pc;
    logic [31:0] r_fs_pc;
    logic [31:0] r_fs_inst;

    state_t      w_state_nxt;
    logic [31:0] w_req_pc_nxt;
    logic        w_cancel_nxt;
    logic        w_br_pend_nxt;
    logic [31:0] w_br_pc_nxt;
    logic [31:0] w_fs_pc_nxt;
    logic [31:0] w_fs_inst_nxt;

    logic        w_flush;
    logic [31:0] w_flush_target;

    assign w_flush        = exc | eret;
    assign w_flush_target = exc ? EXC_ADDR : epc;

    assign bus.inst_req  = (r_state == S_REQ);
    assign bus.inst_addr = r_req_pc;
    assign bus.fs_valid  = (r_state == S_HOLD);
    assign bus.fs_pc     = r_fs_pc;
    assign bus.fs_inst   = r_fs_inst;

    always_comb begin
        // NOTE: every next-value gets a hold default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        w_state_nxt   = r_state;
        w_req_pc_nxt  = r_req_pc;
        w_cancel_nxt  = r_cancel;
        w_br_pend_nxt = r_br_pend;
        w_br_pc_nxt   = r_br_pc;
        w_fs_pc_nxt   = r_fs_pc;
        w_fs_inst_nxt = r_fs_inst;

        // A branch leaves the current slot alone: it is the delay slot.
        if (w_flush) begin
            w_br_pend_nxt = 1'b0;
        end else if (br_valid) begin
            w_br_pend_nxt = 1'b1;
            w_br_pc_nxt   = br_target;
        end

        unique case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_flush) begin
                    w_req_pc_nxt = w_flush_target;
                end
                if (bus.inst_addr_ok) begin
                    w_state_nxt = S_WAIT;
                    if (w_flush) begin
                        w_cancel_nxt = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (w_flush) begin
                    w_req_pc_nxt = w_flush_target;
                end
                if (bus.inst_data_ok) begin
                    if (r_cancel || w_flush) begin
                        w_cancel_nxt = 1'b0;
                        w_state_nxt  = S_REQ;
                    end else begin
                        w_fs_pc_nxt   = r_req_pc;
                        w_fs_inst_nxt = bus.inst_rdata;
                        w_state_nxt   = S_HOLD;
                    end
                end else if (w_flush) begin
                    w_cancel_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_flush) begin
                    w_req_pc_nxt = w_flush_target;
                    w_state_nxt  = S_REQ;
                end else if (bus.ds_allowin) begin
                    w_state_nxt   = S_REQ;
                    w_br_pend_nxt = 1'b0;
                    if (br_valid) begin
                        w_req_pc_nxt = br_target;
                    end else if (r_br_pend) begin
                        w_req_pc_nxt = r_br_pc;
                    end else begin
                        w_req_pc_nxt = r_fs_pc + 32'd4;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_req_pc  <= RESET_ADDR;
            r_cancel  <= 1'b0;
            r_br_pend <= 1'b0;
            r_br_pc   <= '0;
            r_fs_pc   <= RESET_ADDR;
            r_fs_inst <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_pc  <= w_req_pc_nxt;
            r_cancel  <= w_cancel_nxt;
            r_br_pend <= w_br_pend_nxt;
            r_br_pc   <= w_br_pc_nxt;
            r_fs_pc   <= w_fs_pc_nxt;
            r_fs_inst <= w_fs_inst_nxt;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a vector table for the steady fetch/branch
// flow, then hand-written flush and mid-transaction reset sequences.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic        exc, eret, br_valid;
    logic [31:0] epc, br_target;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .exc       (exc),
        .eret      (eret),
        .epc       (epc),
        .br_valid  (br_valid),
        .br_target (br_target),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ao;
        logic        dok;
        logic [31:0] rd;
        logic        allow;
        logic        br;
        logic [31:0] brt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    localparam int NVEC = 36;
    vec_t tbl [NVEC];

    function automatic vec_t mk(logic ao, logic dok, logic [31:0] rd, logic allow,
                                logic br, logic [31:0] brt, logic e_req,
                                logic [31:0] e_addr, logic e_valid,
                                logic [31:0] e_pc, logic [31:0] e_inst);
        vec_t v;
        v.ao = ao; v.dok = dok; v.rd = rd; v.allow = allow; v.br = br; v.brt = brt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc,
                              input logic [31:0] e_inst);
        check({nm, ".inst_req"}, {31'd0, bus.inst_req}, {31'd0, e_req});
        check({nm, ".inst_addr"}, bus.inst_addr, e_addr);
        check({nm, ".fs_valid"}, {31'd0, bus.fs_valid}, {31'd0, e_valid});
        if (e_valid) begin
            check({nm, ".fs_pc"}, bus.fs_pc, e_pc);
            check({nm, ".fs_inst"}, bus.fs_inst, e_inst);
        end
    endtask

    task automatic drive(input logic x, input logic er, input logic [31:0] ep,
                         input logic br, input logic [31:0] bt, input logic ao,
                         input logic dok, input logic [31:0] rd, input logic al);
        exc = x; eret = er; epc = ep; br_valid = br; br_target = bt;
        bus.inst_addr_ok = ao; bus.inst_data_ok = dok;
        bus.inst_rdata = rd; bus.ds_allowin = al;
    endtask

    // Falling edge: check the state left by the last rising edge, then drive
    // the inputs for the coming one.
    task automatic tick(input string nm, input logic e_req, input logic [31:0] e_addr,
                        input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_inst,
                        input logic x, input logic er, input logic [31:0] ep,
                        input logic ao, input logic dok, input logic [31:0] rd,
                        input logic al, input logic br, input logic [31:0] bt);
        @(negedge clk);
        check_outs(nm, e_req, e_addr, e_valid, e_pc, e_inst);
        drive(x, er, ep, br, bt, ao, dok, rd, al);
    endtask

    initial begin
        tbl[0]  = mk(1, 1, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00000, 0, 32'h0, 32'h0);
        tbl[1]  = mk(0, 1, 32'h11111111, 0, 0, 32'h0,        0, 32'hbfc00000, 0, 32'h0, 32'h0);
        tbl[2]  = mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'hbfc00000, 1, 32'hbfc00000, 32'h11111111);
        tbl[3]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00004, 0, 32'h0, 32'h0);
        tbl[4]  = mk(0, 1, 32'h22222222, 0, 0, 32'h0,        0, 32'hbfc00004, 0, 32'h0, 32'h0);
        tbl[5]  = mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'hbfc00004, 1, 32'hbfc00004, 32'h22222222);
        tbl[6]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00008, 0, 32'h0, 32'h0);
        tbl[7]  = mk(0, 1, 32'h33333333, 0, 0, 32'h0,        0, 32'hbfc00008, 0, 32'h0, 32'h0);
        for (int i = 8; i < 13; i++)
            tbl[i] = mk(1, 1, 32'h5a5a5a5a, 0, 0, 32'h0,     0, 32'hbfc00008, 1, 32'hbfc00008, 32'h33333333);
        tbl[13] = mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'hbfc00008, 1, 32'hbfc00008, 32'h33333333);
        tbl[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc0000c, 0, 32'h0, 32'h0);
        tbl[15] = mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc0000c, 0, 32'h0, 32'h0);
        tbl[16] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hbfc0000c, 0, 32'h0, 32'h0);
        tbl[17] = mk(0, 1, 32'h44444444, 0, 0, 32'h0,        0, 32'hbfc0000c, 0, 32'h0, 32'h0);
        tbl[18] = mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'hbfc0000c, 1, 32'hbfc0000c, 32'h44444444);
        tbl[19] = mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00010, 0, 32'h0, 32'h0);
        tbl[20] = mk(0, 0, 32'h0,        0, 1, 32'hbfc00100, 0, 32'hbfc00010, 0, 32'h0, 32'h0);
        tbl[21] = mk(0, 1, 32'h55555555, 0, 0, 32'h0,        0, 32'hbfc00010, 0, 32'h0, 32'h0);
        tbl[22] = mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'hbfc00010, 1, 32'hbfc00010, 32'h55555555);
        tbl[23] = mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00100, 0, 32'h0, 32'h0);
        tbl[24] = mk(0, 1, 32'h66666666, 0, 0, 32'h0,        0, 32'hbfc00100, 0, 32'h0, 32'h0);
        tbl[25] = mk(0, 0, 32'h0,        1, 1, 32'h80000000, 0, 32'hbfc00100, 1, 32'hbfc00100, 32'h66666666);
        tbl[26] = mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h80000000, 0, 32'h0, 32'h0);
        tbl[27] = mk(0, 1, 32'h77777777, 0, 0, 32'h0,        0, 32'h80000000, 0, 32'h0, 32'h0);
        tbl[28] = mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h80000000, 1, 32'h80000000, 32'h77777777);
        tbl[29] = mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h80000004, 0, 32'h0, 32'h0);
        tbl[30] = mk(0, 1, 32'h88888888, 0, 1, 32'hfffffffc, 0, 32'h80000004, 0, 32'h0, 32'h0);
        tbl[31] = mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h80000004, 1, 32'h80000004, 32'h88888888);
        tbl[32] = mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hfffffffc, 0, 32'h0, 32'h0);
        tbl[33] = mk(0, 1, 32'h99999999, 0, 0, 32'h0,        0, 32'hfffffffc, 0, 32'h0, 32'h0);
        tbl[34] = mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'hfffffffc, 1, 32'hfffffffc, 32'h99999999);
        tbl[35] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h00000000, 0, 32'h0, 32'h0);

        resetn = 1'b0;
        drive(0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs("reset", 0, 32'hbfc00000, 0, 32'h0, 32'h0);
        check("reset.fs_pc", bus.fs_pc, 32'hbfc00000);
        check("reset.fs_inst", bus.fs_inst, 32'h0);
        // Data strobes held high from release on: IDLE must ignore them.
        drive(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h0, 1);
        resetn = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr,
                       tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_inst);
            drive(0, 0, 32'h0, tbl[i].br, tbl[i].brt, tbl[i].ao, tbl[i].dok,
                  tbl[i].rd, tbl[i].allow);
        end

        // Exception while waiting; data arrives two cycles later and is dropped.
        tick("excA", 1, 32'h0,        0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0,        0, 0, 32'h0);
        tick("excB", 0, 32'h0,        0, 0, 0, 1, 0, 32'h0, 0, 0, 32'h0,        0, 0, 32'h0);
        tick("excC", 0, 32'hbfc00380, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0,        0, 0, 32'h0);
        tick("excD", 0, 32'hbfc00380, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'hdeadbeef, 0, 0, 32'h0);
        tick("excE", 1, 32'hbfc00380, 0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0,        0, 0, 32'h0);
        tick("excF", 0, 32'hbfc00380, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'haaaaaaaa, 0, 0, 32'h0);
        // Pend a branch in HOLD, then exc+eret together: exc wins, branch dropped.
        tick("hld1", 0, 32'hbfc00380, 1, 32'hbfc00380, 32'haaaaaaaa,
             0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h12345678);
        tick("hld2", 0, 32'hbfc00380, 1, 32'hbfc00380, 32'haaaaaaaa,
             1, 1, 32'h80001234, 0, 0, 32'h0, 0, 0, 32'h0);
        tick("fl1",  1, 32'hbfc00380, 0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0,        0, 0, 32'h0);
        tick("fl2",  0, 32'hbfc00380, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'hbbbbbbbb, 0, 0, 32'h0);
        tick("fl3",  0, 32'hbfc00380, 1, 32'hbfc00380, 32'hbbbbbbbb,
             0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0);
        // eret in REQ without and with addr_ok (second one cancels the fetch).
        tick("brclr", 1, 32'hbfc00384, 0, 0, 0, 0, 1, 32'h80001234, 0, 0, 32'h0, 0, 0, 32'h0);
        tick("eret1", 1, 32'h80001234, 0, 0, 0, 0, 1, 32'h80002000, 1, 0, 32'h0, 0, 0, 32'h0);
        tick("eret2", 0, 32'h80002000, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'hcccccccc, 0, 0, 32'h0);
        tick("eret3", 1, 32'h80002000, 0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0,        0, 0, 32'h0);

        // Reset during WAIT, stale data_ok right after release.
        tick("rstA", 0, 32'h80002000, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        resetn = 1'b0;
        tick("rstB", 0, 32'hbfc00000, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'heeeeeeee, 0, 0, 32'h0);
        resetn = 1'b1;
        tick("rstC", 1, 32'hbfc00000, 0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0,        0, 0, 32'h0);
        tick("rstD", 0, 32'hbfc00000, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h12121212, 0, 0, 32'h0);
        tick("rstE", 0, 32'hbfc00000, 1, 32'hbfc00000, 32'h12121212,
             0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
